unidade_load_store: RTL

UNIDADE_LOAD_STORE -- requirements
Module: unidade_load_store

---
 rtl/pacote_mips.sv | 10 +
 rtl/alinhador_byte.sv | 26 ++
 rtl/unidade_load_store.sv | 94 +++++++++
 3 files changed

// File: rtl/pacote_mips.sv
// pacote_mips: shared processor constants (data widths, load/store FSM state encoding)
package pacote_mips;
    localparam int LARGURA_PALAVRA = 16;
    localparam int LARGURA_BYTE    = 8;
    localparam logic [2:0] OCIOSO      = 3'd0;
    localparam logic [2:0] LEITURA     = 3'd1;
    localparam logic [2:0] RMW_LEITURA = 3'd2;
    localparam logic [2:0] ESCRITA     = 3'd3;
    localparam logic [2:0] RESPOSTA    = 3'd4;
endpackage

// File: rtl/alinhador_byte.sv
// alinhador_byte: byte lane extraction, sign/zero extension and byte merge
//   palavra_lida     : aligned 16-bit word read from memory
//   lane             : byte lane (address bit 0), 1 = upper byte
//   op_byte          : 1 = byte access, 0 = 16-bit access
//   com_sinal        : 1 = sign-extend byte loads
//   byte_novo        : byte to be stored
//   resultado_carga  : formatted load result
//   palavra_mesclada : read word with the selected lane replaced by byte_novo
module alinhador_byte
    import pacote_mips::*;
(
    input  logic [LARGURA_PALAVRA-1:0] palavra_lida,
    input  logic                       lane,
    input  logic                       op_byte,
    input  logic                       com_sinal,
    input  logic [LARGURA_BYTE-1:0]    byte_novo,
    output logic [LARGURA_PALAVRA-1:0] resultado_carga,
    output logic [LARGURA_PALAVRA-1:0] palavra_mesclada
);
    logic [LARGURA_BYTE-1:0] byte_sel;
    always_comb begin
        byte_sel         = lane ? palavra_lida[15:8] : palavra_lida[7:0];
        resultado_carga  = op_byte ? {{LARGURA_BYTE{com_sinal & byte_sel[7]}}, byte_sel} : palavra_lida;
        palavra_mesclada = lane ? {byte_novo, palavra_lida[7:0]} : {palavra_lida[15:8], byte_novo};
    end
endmodule

// File: rtl/unidade_load_store.sv
// unidade_load_store: load/store unit with byte/halfword access, sign extension and byte-store read-modify-write
//   clock, reset          : clock and synchronous active-high reset
//   req, op_escrita, op_byte, com_sinal, endereco, dado_in : request from the pipeline (sampled while pronto)
//   pronto, concluido, erro_acesso, dado_out               : handshake and load result
//   mem_*                 : data memory port (combinational read, posedge write, little-endian)
module unidade_load_store
    import pacote_mips::*;
#(
    parameter logic [15:0] LIMITE_ENDERECO = 16'h00FF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       req,
    input  logic                       op_escrita,
    input  logic                       op_byte,
    input  logic                       com_sinal,
    input  logic [LARGURA_PALAVRA-1:0] endereco,
    input  logic [LARGURA_PALAVRA-1:0] dado_in,
    output logic                       pronto,
    output logic                       concluido,
    output logic                       erro_acesso,
    output logic [LARGURA_PALAVRA-1:0] dado_out,
    output logic                       mem_permisao_escrita,
    output logic                       mem_permisao_leitura,
    output logic [LARGURA_PALAVRA-1:0] mem_endereco,
    output logic [LARGURA_PALAVRA-1:0] mem_dado_escrita,
    input  logic [LARGURA_PALAVRA-1:0] mem_dado_leitura
);
    logic [2:0]                 estado;
    logic                       escrita_reg;
    logic                       byte_reg;
    logic                       sinal_reg;
    logic                       erro_reg;
    logic [LARGURA_PALAVRA-1:0] addr_reg;
    logic [LARGURA_PALAVRA-1:0] dado_reg;
    logic [LARGURA_PALAVRA-1:0] mesclada_reg;
    logic [LARGURA_PALAVRA-1:0] resultado_carga;
    logic [LARGURA_PALAVRA-1:0] palavra_mesclada;
    logic                       rejeita;

    alinhador_byte u_alinhador (
        .palavra_lida     (mem_dado_leitura),
        .lane             (addr_reg[0]),
        .op_byte          (byte_reg),
        .com_sinal        (sinal_reg),
        .byte_novo        (dado_reg[LARGURA_BYTE-1:0]),
        .resultado_carga  (resultado_carga),
        .palavra_mesclada (palavra_mesclada)
    );

    // Out of range, or a misaligned 16-bit access.
    assign rejeita = (endereco > LIMITE_ENDERECO) | (~op_byte & endereco[0]);

    always_comb begin
        pronto               = estado == OCIOSO;
        concluido            = estado == RESPOSTA;
        erro_acesso          = concluido & erro_reg;
        mem_endereco         = {addr_reg[15:1], 1'b0};
        mem_permisao_leitura = (estado == LEITURA) | (estado == RMW_LEITURA);
        // Reset gates the write strobe so a reset edge can never commit a write.
        mem_permisao_escrita = (estado == ESCRITA) & ~reset;
        mem_dado_escrita     = mem_permisao_escrita ? (byte_reg ? mesclada_reg : dado_reg) : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= OCIOSO;
            dado_out <= '0;
            erro_reg <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: if (req) begin
                    escrita_reg <= op_escrita;
                    byte_reg    <= op_byte;
                    sinal_reg   <= com_sinal;
                    addr_reg    <= endereco;
                    dado_reg    <= dado_in;
                    erro_reg    <= rejeita;
                    estado      <= rejeita ? RESPOSTA : ~op_escrita ? LEITURA : op_byte ? RMW_LEITURA : ESCRITA;
                end
                LEITURA: begin
                    dado_out <= resultado_carga;
                    estado   <= RESPOSTA;
                end
                RMW_LEITURA: begin
                    mesclada_reg <= palavra_mesclada;
                    estado       <= ESCRITA;
                end
                ESCRITA: estado <= RESPOSTA;
                default: estado <= OCIOSO;
            endcase
        end
    end
endmodule
